// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/exec1/exec2 control sequencer with instruction register,
// branch flags, run/step/halt control, memory stalls and a retire counter.
module cpu_sequencer #(
   parameter bit          FAST_BRANCH = 1'b0,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step,
   input  logic             clear,
   input  logic [3:0]       instr_in,
   input  logic             instr_valid,
   input  logic             mem_ready,
   input  logic             acc_zero,
   input  logic             acc_neg,
   output logic [2:0]       state,
   output logic [3:0]       inst,
   output logic [2:0]       jmp_flags,
   output logic             halted,
   output logic             busy,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [3:0] OP_STA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_JMP = 4'b0100;
   localparam logic [3:0] OP_JMI = 4'b0101;
   localparam logic [3:0] OP_JEQ = 4'b0110;
   localparam logic [3:0] OP_STP = 4'b0111;
   localparam logic [3:0] OP_LDA = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC1 = 3'd2,
      ST_EXEC2 = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   state_e           after_retire;
   logic [3:0]       ir_q, ir_d;
   logic             eq_bar_q, eq_bar_d;
   logic             mi_q, mi_d;
   logic             step_mode_q, step_mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_fetch;
   logic             live_eq_bar;
   logic             live_mi;
   logic             taken;
   logic             skip;
   logic             retire;

   // Live branch evaluation during FETCH and the post-retire destination
   always_comb begin
      in_fetch     = (state_q == ST_FETCH);
      live_eq_bar  = ~acc_zero;
      live_mi      = acc_neg;
      taken        = (instr_in == OP_JMP)
                   | ((instr_in == OP_JMI) & live_mi)
                   | ((instr_in == OP_JEQ) & ~live_eq_bar);
      skip         = FAST_BRANCH & in_fetch & instr_valid & taken;
      after_retire = (run && !step_mode_q) ? ST_FETCH : ST_IDLE;
   end

   // Next-state, IR/flag capture and retire decision
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      eq_bar_d    = eq_bar_q;
      mi_d        = mi_q;
      step_mode_d = step_mode_q;
      retire      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d     = ST_FETCH;
               step_mode_d = 1'b0;
            end else if (step) begin
               state_d     = ST_FETCH;
               step_mode_d = 1'b1;
            end
         end
         ST_FETCH: begin
            if (instr_valid) begin
               ir_d     = instr_in;
               eq_bar_d = live_eq_bar;
               mi_d     = live_mi;
               if (skip) begin
                  retire  = 1'b1;
                  state_d = after_retire;
               end else begin
                  state_d = ST_EXEC1;
               end
            end
         end
         ST_EXEC1: begin
            if (ir_q == OP_LDA || ir_q == OP_ADD || ir_q == OP_SUB) begin
               state_d = ST_EXEC2;
            end else if (ir_q == OP_STP) begin
               retire  = 1'b1;
               state_d = ST_HALT;
            end else if (ir_q != OP_STA || mem_ready) begin
               retire  = 1'b1;
               state_d = after_retire;
            end
         end
         ST_EXEC2: begin
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = after_retire;
            end
         end
         ST_HALT: begin
            if (clear) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      cnt_d = cnt_q + CNT_W'(retire);
   end

   // State, instruction register, captured flags and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ir_q        <= 4'b0000;
         eq_bar_q    <= 1'b1;
         mi_q        <= 1'b0;
         step_mode_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         eq_bar_q    <= eq_bar_d;
         mi_q        <= mi_d;
         step_mode_q <= step_mode_d;
         cnt_q       <= cnt_d;
      end
   end

   // Decoder-facing outputs; inst and flags bypass to live values in FETCH
   always_comb begin
      state       = {state_q == ST_EXEC2, state_q == ST_EXEC1, state_q == ST_FETCH};
      busy        = (state_q == ST_FETCH) | (state_q == ST_EXEC1) | (state_q == ST_EXEC2);
      halted      = (state_q == ST_HALT);
      inst        = in_fetch ? instr_in : ir_q;
      jmp_flags   = in_fetch ? {live_eq_bar, live_mi, skip} : {eq_bar_q, mi_q, 1'b0};
      instr_count = cnt_q;
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (slow branch / 16-bit counter and
// fast branch / 4-bit counter) share stimulus; an instruction-level model
// predicts every output each cycle, and directed literals pin key points.
module tb_cpu_sequencer;

   localparam logic [3:0] LDI = 4'b0000;
   localparam logic [3:0] STA = 4'b0001;
   localparam logic [3:0] ADD = 4'b0010;
   localparam logic [3:0] SUB = 4'b0011;
   localparam logic [3:0] JMP = 4'b0100;
   localparam logic [3:0] JMI = 4'b0101;
   localparam logic [3:0] JEQ = 4'b0110;
   localparam logic [3:0] STP = 4'b0111;
   localparam logic [3:0] LDA = 4'b1000;

   logic clk = 1'b0;
   logic rst_n, run, step, clear, instr_valid, mem_ready, acc_zero, acc_neg;
   logic [3:0] instr_in;

   logic [2:0]  st [2];
   logic [3:0]  ins [2];
   logic [2:0]  fl [2];
   logic        hl [2];
   logic        bz [2];
   logic [15:0] cnt0;
   logic [3:0]  cnt1;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model: kind 0 = idle, 1 = active, 2 = halted; pos = cycle within instruction
   int         m_kind  [2] = '{0, 0};
   int         m_pos   [2] = '{0, 0};
   int         m_cnt   [2] = '{0, 0};
   bit         m_stepm [2] = '{0, 0};
   bit         m_eqb   [2] = '{1, 1};
   bit         m_mi    [2] = '{0, 0};
   logic [3:0] m_ir    [2] = '{4'b0000, 4'b0000};

   always #5 clk = ~clk;

   cpu_sequencer #(.FAST_BRANCH(1'b0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear),
      .instr_in(instr_in), .instr_valid(instr_valid), .mem_ready(mem_ready),
      .acc_zero(acc_zero), .acc_neg(acc_neg), .state(st[0]), .inst(ins[0]),
      .jmp_flags(fl[0]), .halted(hl[0]), .busy(bz[0]), .instr_count(cnt0));

   cpu_sequencer #(.FAST_BRANCH(1'b1), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear),
      .instr_in(instr_in), .instr_valid(instr_valid), .mem_ready(mem_ready),
      .acc_zero(acc_zero), .acc_neg(acc_neg), .state(st[1]), .inst(ins[1]),
      .jmp_flags(fl[1]), .halted(hl[1]), .busy(bz[1]), .instr_count(cnt1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit taken(input logic [3:0] op, input logic z, input logic n);
      return (op == JMP) || (op == JMI && n) || (op == JEQ && z);
   endfunction

   task automatic m_retire(input int i);
      m_cnt[i] = (m_cnt[i] + 1) % ((i == 1) ? 16 : 65536);
      if (run && !m_stepm[i]) m_pos[i] = 0;
      else                    m_kind[i] = 0;
   endtask

   task automatic m_step(input int i);
      bit fast;
      fast = (i == 1);
      case (m_kind[i])
         0: if (run || step) begin
               m_kind[i]  = 1;
               m_pos[i]   = 0;
               m_stepm[i] = !run;
            end
         2: if (clear) m_kind[i] = 0;
         default: begin
            if (m_pos[i] == 0) begin
               if (instr_valid) begin
                  m_ir[i]  = instr_in;
                  m_eqb[i] = !acc_zero;
                  m_mi[i]  = acc_neg;
                  if (fast && taken(instr_in, acc_zero, acc_neg)) m_retire(i);
                  else m_pos[i] = 1;
               end
            end else if (m_pos[i] == 1) begin
               if (m_ir[i] == STP) begin
                  m_cnt[i]  = (m_cnt[i] + 1) % ((i == 1) ? 16 : 65536);
                  m_kind[i] = 2;
               end else if (m_ir[i] == LDA || m_ir[i] == ADD || m_ir[i] == SUB) begin
                  m_pos[i] = 2;
               end else if (!(m_ir[i] == STA && !mem_ready)) begin
                  m_retire(i);
               end
            end else begin
               if (mem_ready) m_retire(i);
            end
         end
      endcase
   endtask

   // Model advance on each clock edge; async reset clears it
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_kind[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_stepm[i] = 1'b0;
            m_eqb[i] = 1'b1; m_mi[i] = 1'b0; m_ir[i] = 4'b0000;
         end else begin
            m_step(i);
         end
      end
   end

   // Compare every output of both instances against the model mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            bit f;
            logic [2:0] e_st;
            f    = (m_kind[i] == 1) && (m_pos[i] == 0);
            e_st = (m_kind[i] == 1) ? 3'(1 << m_pos[i]) : 3'b000;
            chk($sformatf("state%0d", i), 32'(st[i]), 32'(e_st));
            chk($sformatf("inst%0d", i), 32'(ins[i]), 32'(f ? instr_in : m_ir[i]));
            chk($sformatf("flags%0d", i), 32'(fl[i]),
                f ? 32'({~acc_zero, acc_neg, (i == 1) && instr_valid && taken(instr_in, acc_zero, acc_neg)})
                  : 32'({m_eqb[i], m_mi[i], 1'b0}));
            chk($sformatf("halted%0d", i), 32'(hl[i]), 32'(m_kind[i] == 2));
            chk($sformatf("busy%0d", i), 32'(bz[i]), 32'(m_kind[i] == 1));
         end
         chk("count0", 32'(cnt0), 32'(m_cnt[0]));
         chk("count1", 32'(cnt1), 32'(m_cnt[1]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0; instr_in = 4'b0000;
      instr_valid = 1'b0; mem_ready = 1'b1; acc_zero = 1'b0; acc_neg = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      chk("rst_state", 32'(st[0]), 32'h0);
      chk("rst_flags", 32'(fl[0]), 32'h4);
      chk("rst_inst", 32'(ins[0]), 32'h0);
      chk("rst_busy", 32'(bz[0]), 32'h0);
      chk("rst_count", 32'(cnt0), 32'h0);

      // ldi, add, stp free-running to HALT
      run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; instr_in = LDI;
      cyc(); chk("p_s1", 32'(st[0]), 32'h1);
      cyc(); chk("p_s2", 32'(st[0]), 32'h2); instr_in = ADD;
      cyc(); chk("p_s3", 32'(st[0]), 32'h1);
      cyc(); chk("p_s4", 32'(st[0]), 32'h2);
      cyc(); chk("p_s5", 32'(st[0]), 32'h4); instr_in = STP;
      cyc(); chk("p_s6", 32'(st[0]), 32'h1);
      cyc(); chk("p_s7", 32'(st[0]), 32'h2);
      cyc(); chk("p_s8", 32'(st[0]), 32'h0);
      chk("p_halted", 32'(hl[0]), 32'h1);
      chk("p_count0", 32'(cnt0), 32'd3);
      chk("p_count1", 32'(cnt1), 32'd3);

      // HALT ignores run and step; clear returns to IDLE then FETCH
      step = 1'b1;
      cyc(); cyc();
      chk("h_state", 32'(st[0]), 32'h0);
      chk("h_halted", 32'(hl[0]), 32'h1);
      step = 1'b0; clear = 1'b1;
      cyc(); clear = 1'b0;
      chk("h_clr_state", 32'(st[0]), 32'h0);
      chk("h_clr_halted", 32'(hl[0]), 32'h0);
      cyc(); chk("h_fetch", 32'(st[0]), 32'h1);

      // Fast-branch jeq taken vs not taken; captured flags hold in EXEC1
      do_reset();
      run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; instr_in = JEQ;
      acc_zero = 1'b1; acc_neg = 1'b1;
      cyc();
      chk("b_flags1", 32'(fl[1]), 32'h3);
      chk("b_flags0", 32'(fl[0]), 32'h2);
      chk("b_inst1", 32'(ins[1]), 32'(JEQ));
      cyc();
      chk("b_skip_state1", 32'(st[1]), 32'h1);
      chk("b_skip_count1", 32'(cnt1), 32'd1);
      chk("b_exec_state0", 32'(st[0]), 32'h2);
      acc_zero = 1'b0; acc_neg = 1'b0; #1;
      chk("b_capt_flags0", 32'(fl[0]), 32'h2);
      chk("b_live_flags1", 32'(fl[1]), 32'h4);
      cyc();
      chk("b_nt_state1", 32'(st[1]), 32'h2);
      run = 1'b0;
      repeat (4) cyc();
      instr_in = JMP; step = 1'b1;
      cyc(); step = 1'b0;
      chk("b_jmp_flags1", 32'(fl[1]), 32'h5);
      cyc();
      chk("b_jmp_idle1", 32'(st[1]), 32'h0);
      chk("b_jmp_exec0", 32'(st[0]), 32'h2);
      repeat (3) cyc();

      // Single step on lda with three EXEC2 wait states; extra step ignored
      do_reset();
      instr_valid = 1'b1; mem_ready = 1'b1; instr_in = LDA; step = 1'b1;
      cyc(); step = 1'b0;
      cyc(); mem_ready = 1'b0;
      cyc(); chk("w_e0", 32'(st[0]), 32'h4);
      cyc(); chk("w_e1", 32'(st[0]), 32'h4); step = 1'b1;
      cyc(); chk("w_e2", 32'(st[0]), 32'h4); step = 1'b0;
      cyc(); chk("w_e3", 32'(st[0]), 32'h4); mem_ready = 1'b1;
      cyc(); chk("w_idle", 32'(st[0]), 32'h0);
      chk("w_count0", 32'(cnt0), 32'd1);
      cyc(); chk("w_still_idle", 32'(st[0]), 32'h0);

      // FETCH held while instr_valid is low
      instr_in = ADD; instr_valid = 1'b0; step = 1'b1;
      cyc(); step = 1'b0;
      chk("f_enter", 32'(st[0]), 32'h1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("f_hold", 32'(st[0]), 32'h1);
         chk("f_count", 32'(cnt0), 32'd1);
      end
      instr_valid = 1'b1;
      cyc(); instr_in = STP; #1;
      chk("f_ir", 32'(ins[0]), 32'(ADD));
      cyc(); cyc();
      chk("f_count2", 32'(cnt0), 32'd2);

      // Asynchronous reset in the middle of EXEC2
      run = 1'b1; instr_in = SUB; mem_ready = 1'b0;
      cyc(); cyc(); cyc(); cyc();
      chk("r_pre", 32'(st[0]), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("r_state", 32'(st[0]), 32'h0);
      chk("r_count0", 32'(cnt0), 32'h0);
      chk("r_count1", 32'(cnt1), 32'h0);

      // Seventeen NOPs wrap the 4-bit counter to 1
      do_reset();
      run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; instr_in = 4'b1001;
      cyc();
      for (int k = 0; k < 34; k++) begin
         instr_in = (k < 17) ? 4'b1001 : 4'b1100;
         cyc();
      end
      chk("n_count1", 32'(cnt1), 32'd1);
      chk("n_count0", 32'(cnt0), 32'd17);
      run = 1'b0;
      repeat (3) cyc();
      chk("n_idle", 32'(st[0]), 32'h0);
      chk("n_count0b", 32'(cnt0), 32'd18);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
